// File: rtl/flash_cmd_assembler_if.sv
// Byte link in, flash command word out.
// Groups the MCU byte stream and the command-receiver side.
interface flash_cmd_assembler_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_frame_err;
  logic [31:0] cmd;
  logic        start_trs;
  logic        bad_header;
  logic        timeout_err;
  logic        overrun_err;
  logic [15:0] word_cnt;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    input  cmd,
    input  start_trs,
    input  bad_header,
    input  timeout_err,
    input  overrun_err,
    input  word_cnt
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    output cmd,
    output start_trs,
    output bad_header,
    output timeout_err,
    output overrun_err,
    output word_cnt
  );
endinterface

// File: rtl/flash_cmd_assembler.sv
// Packs MCU bytes into 32-bit flash commands with header
// check, inter-byte timeout, one-word pending and strobe spacing.
module flash_cmd_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 240000,
  parameter int unsigned HOLD_CYCLES    = 8
) (
  input  logic clk,
  input  logic rst,
  flash_cmd_assembler_if.slave bus
);

  localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  HOLD_INIT = 8'(HOLD_CYCLES);

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_t;

  logic [1:0]  idx_r;
  logic [23:0] word_r;
  logic [23:0] tcnt_r;
  logic [31:0] pend_r;
  logic        pend_v_r;
  state_t      state_r;
  state_t      state_n;
  logic [7:0]  hold_r;
  logic [7:0]  hold_n;
  logic [31:0] cmd_r;
  logic        st_r;
  logic        bh_r;
  logic        te_r;
  logic        oe_r;
  logic [15:0] word_cnt_r;

  logic        hdr_ok;
  logic        byte_ok;
  logic        frame_drop;
  logic        accept;
  logic        hdr_bad;
  logic        word_done;
  logic        expire;
  logic        issue;
  logic [31:0] full_word;

  // Recognise the legal command header bytes.
  always_comb begin
    hdr_ok = 1'b0;
    case (bus.rx_data)
      8'hA0, 8'hAC, 8'hAD,
      8'hAE, 8'hAF, 8'hB0: hdr_ok = 1'b1;
      default:             hdr_ok = 1'b0;
    endcase
  end

  assign byte_ok    = bus.rx_valid & ~bus.rx_frame_err;
  assign frame_drop = bus.rx_valid & bus.rx_frame_err;
  assign accept     = byte_ok & ((idx_r != 2'd0) | hdr_ok);
  assign hdr_bad    = byte_ok & (idx_r == 2'd0) & ~hdr_ok;
  assign word_done  = accept & (idx_r == 2'd3);
  assign expire     = ~bus.rx_valid & (idx_r != 2'd0)
                    & (tcnt_r == TO_LAST);
  assign full_word  = {word_r, bus.rx_data};

  // Byte position, partial word and inter-byte idle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r  <= 2'd0;
      word_r <= 24'd0;
      tcnt_r <= 24'd0;
    end else if (frame_drop) begin
      idx_r  <= 2'd0;
      tcnt_r <= 24'd0;
    end else if (accept) begin
      case (idx_r)
        2'd0:    word_r[23:16] <= bus.rx_data;
        2'd1:    word_r[15:8]  <= bus.rx_data;
        2'd2:    word_r[7:0]   <= bus.rx_data;
        default: word_r        <= word_r;
      endcase
      idx_r  <= idx_r + 2'd1;
      tcnt_r <= 24'd0;
    end else if (expire) begin
      idx_r  <= 2'd0;
      tcnt_r <= 24'd0;
    end else if (idx_r != 2'd0 && !bus.rx_valid) begin
      tcnt_r <= tcnt_r + 24'd1;
    end
  end

  // One-word pending slot; a drain in the same cycle frees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r   <= 32'd0;
      pend_v_r <= 1'b0;
    end else if (word_done && (!pend_v_r || issue)) begin
      pend_r   <= full_word;
      pend_v_r <= 1'b1;
    end else if (issue) begin
      pend_v_r <= 1'b0;
    end
  end

  // Output FSM state and hold counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      hold_r  <= 8'd0;
    end else begin
      state_r <= state_n;
      hold_r  <= hold_n;
    end
  end

  // Issue from IDLE, then hold off for the configured spacing.
  always_comb begin
    state_n = state_r;
    hold_n  = hold_r;
    issue   = 1'b0;
    unique case (state_r)
      ST_IDLE: begin
        if (pend_v_r) begin
          issue   = 1'b1;
          state_n = ST_HOLD;
          hold_n  = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (hold_r <= 8'd1) begin
          state_n = ST_IDLE;
        end else begin
          hold_n = hold_r - 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered command, strobe, error pulses and word count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_r      <= 32'd0;
      st_r       <= 1'b0;
      bh_r       <= 1'b0;
      te_r       <= 1'b0;
      oe_r       <= 1'b0;
      word_cnt_r <= 16'd0;
    end else begin
      st_r <= issue;
      bh_r <= hdr_bad;
      te_r <= expire;
      oe_r <= word_done & pend_v_r & ~issue;
      if (issue) begin
        cmd_r      <= pend_r;
        word_cnt_r <= word_cnt_r + 16'd1;
      end
    end
  end

  assign bus.cmd         = cmd_r;
  assign bus.start_trs   = st_r;
  assign bus.bad_header  = bh_r;
  assign bus.timeout_err = te_r;
  assign bus.overrun_err = oe_r;
  assign bus.word_cnt    = word_cnt_r;

endmodule
